n_ch_mixer: RTL
===============

Name: n_ch_mixer

Overview:
- Generalised successor of the two-channel event mixer: merges NUM_CH independent 64-bit word streams onto one output stream.
- Each channel has its own internal FIFO. A channel requests service once it holds a full burst.
- A round-robin arbiter grants one channel at a time and streams exactly one burst through a registered valid/ready output stage.
- Sits between the per-channel data producers and the downstream merger/DMA path.

Parameters:
- DATA_WIDTH, 64, word width in bits (multiple of 4).
- NUM_CH, 4, number of input channels (2..16).
- FIFO_DEPTH, 512, words per channel FIFO (power of two).
- PROG_FULL_THRESH, 480, occupancy at or above which a channel deasserts ready.
- BURST_LEN, 16, words per granted burst (1..FIFO_DEPTH).
- TIMEOUT_CYCLES, 1024, idle-flush timeout; used only with the optional feature.

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- CH_DIN  in  NUM_CH*DATA_WIDTH  channel k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
- CH_iVALID  in  NUM_CH  per-channel write strobe.
- CH_oREADY  out  NUM_CH  per-channel ready; high while occupancy < PROG_FULL_THRESH.
- CH_OVERFLOW  out  NUM_CH  sticky flag: a write was attempted while ready was low.
- DOUT  out  DATA_WIDTH  merged output word.
- oVALID  out  1  DOUT valid.
- iREADY  in  1  downstream ready.
- GRANT_CH  out  clog2(NUM_CH)  channel currently or most recently granted.

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous and active-high. All state updates on posedge CLK.
- Reset values:
  - DOUT = {DATA_WIDTH/4{4'hE}}; oVALID = 0; GRANT_CH = 0; CH_OVERFLOW = 0.
  - All FIFO occupancies = 0; round-robin pointer = 0; FSM = IDLE.
  - CH_oREADY is 0 while RESET is high and all-ones in the first cycle after RESET deasserts.
- Write:
  - A word is accepted when CH_iVALID[k] and CH_oREADY[k] are both high; occupancy updates next cycle.
  - CH_iVALID[k] with CH_oREADY[k] low: the word is dropped and CH_OVERFLOW[k] sets, cleared only by RESET.
  - A simultaneous write and pop on the same channel leaves occupancy unchanged.
- Request: req[k] = occupancy[k] >= BURST_LEN, evaluated on registered occupancy.
- FSM:
  - IDLE: if any req, grant the first requesting channel searching upward from (last grant + 1) mod NUM_CH. Load GRANT_CH, load burst counter = BURST_LEN, go to BURST. With no request, stay in IDLE.
  - BURST: pop one word from the granted FIFO each cycle in which (!oVALID || iREADY). The popped word loads DOUT with oVALID = 1 on the next edge. Decrement the counter per pop; on the last pop go to DRAIN.
  - DRAIN: wait until the output register is empty or accepted (!oVALID || iREADY), then go to IDLE. At least one IDLE cycle always occurs between bursts.
- Output handshake:
  - While oVALID && !iREADY, DOUT and oVALID hold stable.
  - oVALID drops the cycle after the last word is accepted if no new pop occurred.
- Latency: request seen in IDLE at cycle t; first word on DOUT/oVALID at t+2. Back-to-back words follow at one per cycle while iREADY is high.
- Fairness: a channel cannot be granted twice while another channel's req stayed high across the intervening IDLE evaluation.
- Bursts are never interleaved. A granted burst always completes with exactly BURST_LEN words (availability is guaranteed by req).
- RESET mid-burst: the burst is abandoned, in-flight DOUT is discarded, and all FIFOs are cleared.

Optional Feature:
- Macro: N_CH_MIXER_FLUSH_TIMEOUT_EN.
- Defined:
  - Each channel has an idle counter that increments while 0 < occupancy < BURST_LEN and the channel is not granted. It resets on grant or when occupancy is 0.
  - When the counter reaches TIMEOUT_CYCLES, the channel raises req. Its granted burst length is the occupancy snapshot taken at grant time (1..BURST_LEN-1).
  - Full-burst requests take priority over timeout requests in the same IDLE cycle.
- Undefined: partial data waits indefinitely until BURST_LEN words accumulate; no idle counters are instantiated.

Test Plan:
- Reset check: hold RESET 3 cycles -> DOUT = 64'hEEEEEEEEEEEEEEEE, oVALID = 0, CH_oREADY = 4'b0000 during reset and 4'b1111 the following cycle.
- Single channel: write 16 words 0x100..0x10F to ch2 with iREADY = 1 -> DOUT shows 0x100..0x10F in order on consecutive cycles, GRANT_CH = 2, first word 2 cycles after the request.
- Round-robin: all 4 channels each hold 32 words -> grant order 0,1,2,3,0,1,2,3, each burst exactly 16 words, never interleaved.
- Backpressure: toggle iREADY as 1,0,0,1 repeating during a burst -> DOUT stable while stalled, no word lost or duplicated, 16 words total.
- Overflow: fill ch1 to 480 words with iREADY = 0, then write one more -> CH_oREADY[1] = 0, CH_OVERFLOW[1] = 1, occupancy stays 480. Apply RESET mid-burst -> oVALID = 0 the next cycle and all occupancies are 0.
- With N_CH_MIXER_FLUSH_TIMEOUT_EN defined and TIMEOUT_CYCLES = 1024: write 5 words to ch3 -> a 5-word burst is emitted 1024 cycles after the fifth write; without the macro, no output appears.

Source files
------------

// File: rtl/n_ch_mixer.sv
// NUM_CH-channel burst mixer: per-channel FIFOs, round-robin burst arbiter, registered valid/ready output.
// Optional idle-flush of partial bursts when N_CH_MIXER_FLUSH_TIMEOUT_EN is defined.
module n_ch_mixer #(
  parameter int DATA_WIDTH       = 64,
  parameter int NUM_CH           = 4,
  parameter int FIFO_DEPTH       = 512,
  parameter int PROG_FULL_THRESH = 480,
  parameter int BURST_LEN        = 16,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DIN,
  input  logic [NUM_CH-1:0]            CH_iVALID,
  output logic [NUM_CH-1:0]            CH_oREADY,
  output logic [NUM_CH-1:0]            CH_OVERFLOW,
  output logic [DATA_WIDTH-1:0]        DOUT,
  output logic                         oVALID,
  input  logic                         iREADY,
  output logic [$clog2(NUM_CH)-1:0]    GRANT_CH
);

  localparam int GW    = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  logic [DATA_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NUM_CH];
  logic [PTR_W-1:0]      rd_ptr [NUM_CH];
  logic [OCC_W-1:0]      occ    [NUM_CH];
  logic [NUM_CH-1:0]     wr_en;
  logic [NUM_CH-1:0]     pop_en;
  logic [NUM_CH-1:0]     full_req;
  state_t                state;
  logic [CNT_W-1:0]      burst_cnt;
  logic [GW-1:0]         rr_ptr;
  logic                  pop;
  logic [GW:0]           pick;
  logic [CNT_W-1:0]      next_len;

  // Returns {found, index} of the first set bit searching upward from start, wrapping.
  function automatic logic [GW:0] rr_pick(input logic [NUM_CH-1:0] r, input logic [GW-1:0] start);
    logic [GW:0] res;
    int idx;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NUM_CH;
      if (r[idx]) res = {1'b1, GW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    pop = (state == BURST) && (!oVALID || iREADY);
    for (int k = 0; k < NUM_CH; k++) begin
      CH_oREADY[k] = !RESET && (occ[k] < OCC_W'(PROG_FULL_THRESH));
      wr_en[k]     = CH_iVALID[k] && CH_oREADY[k];
      pop_en[k]    = pop && (GRANT_CH == GW'(k));
      full_req[k]  = occ[k] >= OCC_W'(BURST_LEN);
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= CH_DIN[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
      end
      CH_OVERFLOW <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop_en[k]) rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        case ({wr_en[k], pop_en[k]})
          2'b10:   occ[k] <= occ[k] + OCC_W'(1);
          2'b01:   occ[k] <= occ[k] - OCC_W'(1);
          default: occ[k] <= occ[k];
        endcase
        if (CH_iVALID[k] && !CH_oREADY[k]) CH_OVERFLOW[k] <= 1'b1;
      end
    end
  end

`ifdef N_CH_MIXER_FLUSH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]   idle_cnt [NUM_CH];
  logic [NUM_CH-1:0] to_req;
  logic [GW:0]       full_pick;
  logic [GW:0]       to_pick;

  // Partial data ages only while it is below a burst and not being serviced.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CH; k++) idle_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (occ[k] == '0 || full_req[k] || (state != IDLE && GRANT_CH == GW'(k)))
          idle_cnt[k] <= '0;
        else if (idle_cnt[k] != TO_W'(TIMEOUT_CYCLES))
          idle_cnt[k] <= idle_cnt[k] + TO_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) to_req[k] = idle_cnt[k] == TO_W'(TIMEOUT_CYCLES);
    full_pick = rr_pick(full_req, rr_ptr);
    to_pick   = rr_pick(to_req, rr_ptr);
    if (full_pick[GW]) begin
      pick     = full_pick;
      next_len = CNT_W'(BURST_LEN);
    end else begin
      pick     = to_pick;
      next_len = CNT_W'(occ[to_pick[GW-1:0]]);
    end
  end
`else
  always_comb begin
    pick     = rr_pick(full_req, rr_ptr);
    next_len = CNT_W'(BURST_LEN);
  end
`endif

  // rr_ptr holds the next search start, so it is one past the last grant.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      DOUT      <= {(DATA_WIDTH/4){4'hE}};
      oVALID    <= 1'b0;
      GRANT_CH  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      if (oVALID && iREADY) oVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (pick[GW]) begin
            GRANT_CH  <= pick[GW-1:0];
            rr_ptr    <= GW'((int'(pick[GW-1:0]) + 1) % NUM_CH);
            burst_cnt <= next_len;
            state     <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            DOUT      <= mem[GRANT_CH][rd_ptr[GRANT_CH]];
            oVALID    <= 1'b1;
            burst_cnt <= burst_cnt - CNT_W'(1);
            if (burst_cnt == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!oVALID || iREADY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
